// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FWFT FIFO.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer register with increment enable.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // DEPTH is a power of two, so the natural binary rollover is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + ADDR_W'(1);
  end

endmodule

// File: rtl/sync_fifo8.sv
// First-word-fall-through FIFO: head word is driven on dout whenever not empty.
module sync_fifo8
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter int CNT_W    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // A write into a full FIFO is only legal when the same edge frees a slot.
  assign do_wr = wr_en & (~full | rd_en);
  assign do_rd = rd_en & ~empty;

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_wr),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_rd),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en & full & ~rd_en;
      underflow <= rd_en & empty;
    end
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  // Masking with empty also forces dout to zero the instant reset lands.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo8.sv
// Directed self-checking bench for sync_fifo8 with a modelled downstream reader.
module tb_sync_fifo8;
  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo8 dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    #12;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", almost_full); end
    n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_single;
    wr_en = 1'b1; din = 8'hA5;
    tick();
    wr_en = 1'b0;
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout: got %h want a5", dout); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", empty); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after_rd: got %b want 1", empty); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL single_dout_after_rd: got %h want 00", dout); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; din = 8'(i);
      tick();
      n_checks++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
      n_checks++; if (almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i >= 14)); end
      n_checks++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i <= 2)); end
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    din = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
    tick();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      #3;
      n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, 8'(i)); end
      tick();
    end
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL drain_dout_final: got %h want 00", dout); end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'h20 + 8'(i);
      tick();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL rw_full: got %b want 1", full); end
    rd_en = 1'b1; din = 8'h77;
    for (int i = 0; i < 20; i++) begin
      #3;
      n_checks++;
      if (dout !== ((i < 16) ? 8'h20 + 8'(i) : 8'h77)) begin
        n_fail++; $display("FAIL rw_dout[%0d]: got %h want %h", i, dout, (i < 16) ? 8'h20 + 8'(i) : 8'h77);
      end
      tick();
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL rw_count[%0d]: got %0d want 16", i, count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rw_ovf[%0d]: got %b want 0", i, overflow); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #3;
      n_checks++; if (dout !== 8'h77) begin n_fail++; $display("FAIL rw_tail[%0d]: got %h want 77", i, dout); end
      tick();
    end
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rw_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow_wr;
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse: got %b want 1", underflow); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL udf_count: got %0d want 1", count); end
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL udf_dout: got %h want 3c", dout); end
    tick();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b want 0", underflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; din = 8'h90 + 8'(i);
      tick();
    end
    n_checks++; if (count !== 5'd9) begin n_fail++; $display("FAIL arst_precount: got %0d want 9", count); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b want 1", empty); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout: got %h want 00", dout); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL arst_ae: got %b want 1", almost_empty); end
    wr_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    wr_en = 1'b1; din = 8'h5A;
    tick();
    wr_en = 1'b0;
    n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL arst_first: got %h want 5a", dout); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL arst_count_after: got %0d want 1", count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reader;
    logic [7:0] exp_seq [3];
    logic [7:0] data_out;
    int         got;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = exp_seq[i];
      tick();
    end
    wr_en = 1'b0;
    got = 0;
    // Reader: one-cycle rd_en pulse, latch dout at the end of that cycle, then idle one cycle.
    for (int k = 0; k < 12 && !empty; k++) begin
      rd_en = 1'b1;
      @(negedge clk);
      data_out = dout;
      tick();
      rd_en = 1'b0;
      if (got < 3) begin
        n_checks++; if (data_out !== exp_seq[got]) begin n_fail++; $display("FAIL reader_data[%0d]: got %h want %h", got, data_out, exp_seq[got]); end
      end
      got++;
      tick();
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reader_udf[%0d]: got %b want 0", got, underflow); end
    end
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL reader_pops: got %0d want 3", got); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reader_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_rw();
    test_underflow_wr();
    test_async_reset();
    test_reader();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo8.md
Name: sync_fifo8

Overview:
- Synchronous 8-bit first-word-fall-through (FWFT) FIFO that sits directly upstream of the FIFO reader FSM.
- Supplies that reader's data_in and empty inputs and consumes its rd_en output.
- The head word is visible on dout whenever empty=0, so a reader sampling dout on the same edge it holds rd_en high captures the popped word with no extra latency.
- A producer writes on the other side with wr_en/din.

Parameters:
- DATA_W, 8, word width.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  push request.
- din  in  DATA_W  write data.
- rd_en  in  1  pop request.
- dout  out  DATA_W  head-of-FIFO data (FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  one-cycle pulse, write rejected.
- underflow  out  1  one-cycle pulse, read rejected.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0.
  - Storage array is not reset.
  - Deassertion of rst is taken synchronously to clk by the surrounding design.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is tracked separately; there is no extra pointer bit.
- Push accepted (do_wr) = wr_en & (!full | rd_en).
  - A write while full is accepted only when a read occurs in the same cycle.
- Pop accepted (do_rd) = rd_en & !empty.
- On the clk edge:
  - do_wr: mem[wr_ptr] <= din, and wr_ptr increments.
  - do_rd: rd_ptr increments.
  - count changes by +1 on write only, -1 on read only, and is unchanged when both or neither occur.
- Flags (full, empty, almost_*) are combinational decodes of registered count. They update in the cycle after the causing edge.
- dout is combinational: mem[rd_ptr] when empty=0, 8'h00 when empty=1.
  - Write-to-dout latency: a word written into an empty FIFO appears on dout, with empty=0, one cycle after the write edge.
  - A simultaneous read and write on an empty FIFO means the read is rejected and the write is accepted.
- Boundary cases:
  - Full, wr_en=1, rd_en=0: write dropped, overflow=1 for one cycle, storage and pointers untouched.
  - Empty, rd_en=1: nothing pops, underflow=1 for one cycle. underflow is still flagged if wr_en=1 in the same cycle.
  - Full, wr_en=1, rd_en=1: both accepted, count stays DEPTH, the head advances, and the new word lands in the slot just freed.
  - Pointer wrap from DEPTH-1 to 0 is seamless; data order is preserved across the wrap.
  - overflow and underflow are registered pulses, asserted in the cycle after the offending edge.
- Reset mid-operation: all state clears immediately; in-flight words are discarded and dout goes to 0 at once.
- Reader compatibility: the reader drives rd_en high for exactly one cycle and samples dout at the end of that cycle. Because dout is FWFT, the sampled value is the word being popped.
- There is no FSM. Control is the pointer/count datapath plus registered pulse flags.

Decomposition:
- Package fifo_pkg holds DATA_W=8, the DEPTH default, and the derived ADDR_W/CNT_W localparam functions.
- One sub-module, fifo_ptr: a parameterised modulo-DEPTH pointer register with an increment enable and async active-low reset. It is instantiated twice, for the write and read pointers.
- Storage, count and flag logic live in the top module.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, dout=8'h00, almost_empty=1.
- Write 8'hA5 in one cycle -> next cycle dout=8'hA5, empty=0, count=1. Then rd_en for one cycle -> following cycle empty=1, dout=8'h00.
- Write 16 words 8'h01..8'h10 -> full=1, almost_full high from count=14. A 17th write of 8'hFF -> overflow pulse, count=16. Then 16 reads return 01..10 in order; 8'hFF is never seen.
- Fill to full, then wr_en=rd_en=1 with din=8'h77 for 20 cycles -> count stays 16, no overflow, reads return the original data followed by 77s, pointers wrap correctly.
- Empty FIFO with rd_en=1 and wr_en=1, din=8'h3C -> underflow pulse, count=1, dout=8'h3C next cycle.
- Drive rst low mid-burst with count=9, asynchronously between edges -> outputs take their reset values immediately. After release, a write of 8'h5A reads back first.
- Connect the reader FSM downstream and push 8'h11, 8'h22, 8'h33 -> reader's data_out shows 11, 22, 33 in sequence; empty returns to 1 and there is no underflow.
